// File: rtl/rocc_accum_unit_pkg.sv
// Shared RoCC command/response types and accumulator-unit opcodes.
package rocc_accum_unit_pkg;

    localparam int unsigned XLEN = 64;

    // Custom-instruction word as delivered by the core's RoCC port.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic       xd;
        logic       xs1;
        logic       xs2;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rocc_inst_t;

    typedef struct packed {
        rocc_inst_t      inst;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } rocc_cmd_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } rocc_resp_t;

    localparam logic [6:0] ACC_LOAD = 7'd0;
    localparam logic [6:0] ACC_ADD  = 7'd1;
    localparam logic [6:0] ACC_READ = 7'd2;
    localparam logic [6:0] ACC_MAC  = 7'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } acc_state_e;

endpackage

// File: rtl/rocc_accum_unit_serial_mul64.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low 64 bits of product.
module serial_mul64
    import rocc_accum_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_c_o,
    output logic [XLEN-1:0] product_c_o
);

    localparam int unsigned CntW = $clog2(XLEN);

    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] prod_q, prod_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;
    logic [XLEN-1:0] addend;

    // Next iteration; done/product are valid during the final iteration cycle.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        addend      = b_q[0] ? a_q : '0;
        product_c_o = prod_q + addend;
        done_c_o    = run_q && (cnt_q == CntW'(XLEN - 1));
        if (start_i) begin
            a_d    = a_i;
            b_d    = b_i;
            prod_d = '0;
            cnt_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            prod_d = product_c_o;
            a_d    = a_q << 1;
            b_d    = b_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            if (done_c_o) begin
                run_d = 1'b0;
            end
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/rocc_accum_unit.sv
// RoCC accumulator accelerator: LOAD/ADD/READ/MAC on a bank of 64-bit accumulators.
module rocc_accum_unit
    import rocc_accum_unit_pkg::*;
#(
    parameter int unsigned NumAcc = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  rocc_cmd_t  rocc_cmd_i,
    input  logic       rocc_cmd_valid_i,
    output logic       rocc_cmd_ready_o,
    output rocc_resp_t rocc_resp_o,
    output logic       rocc_resp_valid_o,
    input  logic       rocc_resp_ready_i,
    output logic       busy_o
);

    localparam int unsigned IdxW = $clog2(NumAcc);

    acc_state_e      state_q, state_d;
    logic [XLEN-1:0] acc_q [NumAcc];
    logic [XLEN-1:0] acc_d [NumAcc];
    rocc_resp_t      resp_q, resp_d;
    logic [IdxW-1:0] op_idx_q, op_idx_d;
    logic [4:0]      op_rd_q, op_rd_d;
    logic            op_xd_q, op_xd_d;
    logic            ready_q, busy_q, resp_valid_q;

    logic [IdxW-1:0] cmd_idx;
    logic [XLEN-1:0] op_res;
    logic [XLEN-1:0] mac_sum;
    logic            mul_start;
    logic            mul_done_c;
    logic [XLEN-1:0] mul_product_c;
    logic            unused_cmd_bits;

    assign cmd_idx         = rocc_cmd_i.inst.rs2[IdxW-1:0];
    assign unused_cmd_bits = ^{rocc_cmd_i.inst.opcode, rocc_cmd_i.inst.rs1,
                               rocc_cmd_i.inst.xs1, rocc_cmd_i.inst.xs2,
                               rocc_cmd_i.inst.rs2};

    serial_mul64 u_mul (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (mul_start),
        .a_i         (rocc_cmd_i.rs1),
        .b_i         (rocc_cmd_i.rs2),
        .done_c_o    (mul_done_c),
        .product_c_o (mul_product_c)
    );

    // Command decode, accumulator update and next state.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        resp_d    = resp_q;
        op_idx_d  = op_idx_q;
        op_rd_d   = op_rd_q;
        op_xd_d   = op_xd_q;
        mul_start = 1'b0;
        op_res    = '1;
        mac_sum   = acc_q[op_idx_q] + mul_product_c;
        unique case (state_q)
            ST_IDLE: begin
                if (rocc_cmd_valid_i) begin
                    case (rocc_cmd_i.inst.funct7)
                        ACC_LOAD: op_res = rocc_cmd_i.rs1;
                        ACC_ADD:  op_res = acc_q[cmd_idx] + rocc_cmd_i.rs1;
                        ACC_READ: op_res = acc_q[cmd_idx];
                        default:  op_res = '1;
                    endcase
                    if (rocc_cmd_i.inst.funct7 == ACC_MAC) begin
                        mul_start = 1'b1;
                        op_idx_d  = cmd_idx;
                        op_rd_d   = rocc_cmd_i.inst.rd;
                        op_xd_d   = rocc_cmd_i.inst.xd;
                        state_d   = ST_MUL;
                    end else begin
                        if ((rocc_cmd_i.inst.funct7 == ACC_LOAD) ||
                            (rocc_cmd_i.inst.funct7 == ACC_ADD)) begin
                            acc_d[cmd_idx] = op_res;
                        end
                        if (rocc_cmd_i.inst.xd) begin
                            resp_d  = '{rd: rocc_cmd_i.inst.rd, data: op_res};
                            state_d = ST_RESP;
                        end
                    end
                end
            end
            ST_MUL: begin
                if (mul_done_c) begin
                    acc_d[op_idx_q] = mac_sum;
                    if (op_xd_q) begin
                        resp_d  = '{rd: op_rd_q, data: mac_sum};
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP: begin
                if (rocc_resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, accumulator bank and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < int'(NumAcc); i++) begin
                acc_q[i] <= '0;
            end
            resp_q       <= '0;
            op_idx_q     <= '0;
            op_rd_q      <= '0;
            op_xd_q      <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            resp_q       <= resp_d;
            op_idx_q     <= op_idx_d;
            op_rd_q      <= op_rd_d;
            op_xd_q      <= op_xd_d;
            ready_q      <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            resp_valid_q <= (state_d == ST_RESP);
        end
    end

    assign rocc_cmd_ready_o  = ready_q;
    assign busy_o            = busy_q;
    assign rocc_resp_valid_o = resp_valid_q;
    assign rocc_resp_o       = resp_q;

endmodule
